// File: rtl/fir_coefficient_loader_if.sv
// Control-port and AXI-Stream bundle between a coefficient master, the loader and fir_filter.
// The master side writes the store and requests loads; the slave side is the loader itself.
interface fir_coefficient_loader_if #(
    parameter int COEFFICIENT_WIDTH = 16,
    parameter int BANK_WIDTH        = 1,
    parameter int ADDR_WIDTH        = 4
);
    logic                         wr_en;
    logic [BANK_WIDTH-1:0]        wr_bank;
    logic [ADDR_WIDTH-1:0]        wr_addr;
    logic [COEFFICIENT_WIDTH-1:0] wr_data;
    logic                         load_start;
    logic [BANK_WIDTH-1:0]        load_bank;
    logic                         busy;
    logic                         load_done;
    logic                         load_error;
    logic                         coefficients_out_aresetn;
    logic                         coefficients_out_tvalid;
    logic [COEFFICIENT_WIDTH-1:0] coefficients_out_tdata;
    logic                         coefficients_out_tlast;
    logic                         coefficients_out_tready;

    modport master (
        output wr_en, wr_bank, wr_addr, wr_data, load_start, load_bank,
        output coefficients_out_tready,
        input  busy, load_done, load_error,
        input  coefficients_out_aresetn, coefficients_out_tvalid,
        input  coefficients_out_tdata, coefficients_out_tlast
    );

    modport slave (
        input  wr_en, wr_bank, wr_addr, wr_data, load_start, load_bank,
        input  coefficients_out_tready,
        output busy, load_done, load_error,
        output coefficients_out_aresetn, coefficients_out_tvalid,
        output coefficients_out_tdata, coefficients_out_tlast
    );
endinterface

// File: rtl/fir_coefficient_loader.sv
// Banked coefficient store that clears a fir_filter tap index, then streams one bank over AXI-Stream.
//   state  | meaning
//   IDLE   | waiting for load_start; aresetn high, busy low
//   CLEAR  | aresetn held low for CLEAR_CYCLES cycles
//   STREAM | presenting taps, one beat per tvalid&tready
//   DONE   | load_done pulse, busy drops on exit
module fir_coefficient_loader #(
    parameter int NUMBER_TAPS       = 16,
    parameter int COEFFICIENT_WIDTH = 16,
    parameter int NUM_BANKS         = 2,
    parameter int CLEAR_CYCLES      = 2,
    parameter int REVERSE_ORDER     = 0
) (
    input logic                     clock,
    input logic                     reset,
    fir_coefficient_loader_if.slave bus
);
    localparam int BW  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int AW  = (NUMBER_TAPS > 1) ? $clog2(NUMBER_TAPS) : 1;
    localparam int CCW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam int CW  = COEFFICIENT_WIDTH;
    localparam logic [AW-1:0]  LAST_BEAT  = AW'(NUMBER_TAPS - 1);
    localparam logic [CCW-1:0] CLEAR_LOAD = CCW'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_STREAM, S_DONE} state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic [CW-1:0]  r_store [NUM_BANKS][NUMBER_TAPS];

    logic [BW-1:0]  r_bank,    w_bank_d;
    logic [AW-1:0]  r_beat,    w_beat_d;
    logic [CCW-1:0] r_clr_cnt, w_clr_cnt_d;
    logic           r_busy,    w_busy_d;
    logic           r_done,    w_done_d;
    logic           r_error,   w_error_d;
    logic           r_aresetn, w_aresetn_d;
    logic           r_tvalid,  w_tvalid_d;
    logic           r_tlast,   w_tlast_d;
    logic [CW-1:0]  r_tdata,   w_tdata_d;

    logic           w_wr_bank_ok;
    logic           w_wr_addr_ok;
    logic           w_load_bank_ok;
    logic           w_wr_ok;
    logic           w_load_err;
    logic           w_wr_err;
    logic           w_transfer;
    logic           w_last_beat;
    logic           w_clr_expired;
    logic [AW-1:0]  w_beat_next;
    logic [AW-1:0]  w_rd_beat;
    logic [AW-1:0]  w_rd_addr;
    logic [CW-1:0]  w_rd_data;

    // Range checks only exist when the select field can encode more entries than are stored.
    generate
        if ((1 << BW) > NUM_BANKS) begin : g_bank_chk
            assign w_wr_bank_ok   = 32'(bus.wr_bank) < NUM_BANKS;
            assign w_load_bank_ok = 32'(bus.load_bank) < NUM_BANKS;
        end else begin : g_bank_full
            assign w_wr_bank_ok   = 1'b1;
            assign w_load_bank_ok = 1'b1;
        end
        if ((1 << AW) > NUMBER_TAPS) begin : g_addr_chk
            assign w_wr_addr_ok = 32'(bus.wr_addr) < NUMBER_TAPS;
        end else begin : g_addr_full
            assign w_wr_addr_ok = 1'b1;
        end
    endgenerate

    assign w_wr_ok       = bus.wr_en & w_wr_bank_ok & w_wr_addr_ok;
    assign w_wr_err      = bus.wr_en & ~(w_wr_bank_ok & w_wr_addr_ok);
    assign w_load_err    = bus.load_start & ((r_state != S_IDLE) | ~w_load_bank_ok);
    assign w_transfer    = r_tvalid & bus.coefficients_out_tready;
    assign w_last_beat   = (r_beat == LAST_BEAT);
    assign w_clr_expired = (r_clr_cnt == '0);
    assign w_beat_next   = r_beat + AW'(1);

    // Beat index is always ascending; reversal is applied only when forming the store address.
    assign w_rd_beat = (r_state == S_STREAM) ? w_beat_next : '0;
    assign w_rd_addr = (REVERSE_ORDER != 0) ? (LAST_BEAT - w_rd_beat) : w_rd_beat;
    assign w_rd_data = r_store[r_bank][w_rd_addr];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int t = 0; t < NUMBER_TAPS; t++) begin
                    r_store[b][t] <= '0;
                end
            end
        end else if (w_wr_ok) begin
            r_store[bus.wr_bank][bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.load_start && w_load_bank_ok) w_state_next = S_CLEAR;
            S_CLEAR:  if (w_clr_expired) w_state_next = S_STREAM;
            S_STREAM: if (w_transfer && w_last_beat) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_bank_d    = r_bank;
        w_beat_d    = r_beat;
        w_clr_cnt_d = r_clr_cnt;
        w_busy_d    = r_busy;
        w_done_d    = 1'b0;
        w_error_d   = w_load_err | w_wr_err;
        w_aresetn_d = r_aresetn;
        w_tvalid_d  = r_tvalid;
        w_tlast_d   = r_tlast;
        w_tdata_d   = r_tdata;
        case (r_state)
            S_IDLE: begin
                w_aresetn_d = 1'b1;
                w_busy_d    = 1'b0;
                if (bus.load_start && w_load_bank_ok) begin
                    w_bank_d    = bus.load_bank;
                    w_beat_d    = '0;
                    w_clr_cnt_d = CLEAR_LOAD;
                    w_aresetn_d = 1'b0;
                    w_busy_d    = 1'b1;
                end
            end
            S_CLEAR: begin
                if (w_clr_expired) begin
                    w_aresetn_d = 1'b1;
                    w_tvalid_d  = 1'b1;
                    w_tdata_d   = w_rd_data;
                    w_tlast_d   = (NUMBER_TAPS == 1);
                end else begin
                    w_clr_cnt_d = r_clr_cnt - CCW'(1);
                end
            end
            S_STREAM: begin
                if (w_transfer) begin
                    if (w_last_beat) begin
                        w_tvalid_d = 1'b0;
                        w_tlast_d  = 1'b0;
                        w_done_d   = 1'b1;
                    end else begin
                        w_beat_d  = w_beat_next;
                        w_tdata_d = w_rd_data;
                        w_tlast_d = (w_beat_next == LAST_BEAT);
                    end
                end
            end
            S_DONE: begin
                w_busy_d = 1'b0;
            end
            default: begin
                w_busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bank    <= '0;
            r_beat    <= '0;
            r_clr_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_aresetn <= 1'b0;
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
            r_tdata   <= '0;
        end else begin
            r_bank    <= w_bank_d;
            r_beat    <= w_beat_d;
            r_clr_cnt <= w_clr_cnt_d;
            r_busy    <= w_busy_d;
            r_done    <= w_done_d;
            r_error   <= w_error_d;
            r_aresetn <= w_aresetn_d;
            r_tvalid  <= w_tvalid_d;
            r_tlast   <= w_tlast_d;
            r_tdata   <= w_tdata_d;
        end
    end

    assign bus.busy                     = r_busy;
    assign bus.load_done                = r_done;
    assign bus.load_error               = r_error;
    assign bus.coefficients_out_aresetn = r_aresetn;
    assign bus.coefficients_out_tvalid  = r_tvalid;
    assign bus.coefficients_out_tdata   = r_tdata;
    assign bus.coefficients_out_tlast   = r_tlast;
endmodule
